// File: rtl/dmem_lsu_ctrl.sv
// dmem_lsu_ctrl: RV32I load/store sequencer for a word bus without byte enables.
// Sub-word stores go through read-modify-write; every bus phase is bounded by a wait counter.
module dmem_lsu_ctrl #(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] load_data,
  output logic        access_err,
  output logic        bus_err,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wd,
  output logic        dmem_we,
  output logic        memaccess,
  input  logic [31:0] dmem_rd,
  input  logic        Dwait
);
  typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_LIMIT);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] rd_buf_q, rd_buf_d, load_data_q, load_data_d;
  logic access_err_q, access_err_d, bus_err_q, bus_err_d;
  logic illegal, misaligned, timeout;
  logic [4:0] bsh, hsh;
  logic [7:0] rd_b;
  logic [15:0] rd_h;
  logic [31:0] ext, merged;
  assign illegal = req_we ? (req_funct3[2] || req_funct3[1:0] == 2'b11)
                          : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
  assign misaligned = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                      (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
  // the edge that would push the count past the limit abandons the access
  assign timeout = Dwait && cnt_q == LIMIT;
  assign bsh = {req_addr[1:0], 3'b000};
  assign hsh = {req_addr[1], 4'b0000};
  assign rd_b = 8'(dmem_rd >> bsh);
  assign rd_h = 16'(dmem_rd >> hsh);
  assign ext = req_funct3[1:0] == 2'b00 ? {{24{~req_funct3[2] & rd_b[7]}}, rd_b}
             : req_funct3[1:0] == 2'b01 ? {{16{~req_funct3[2] & rd_h[15]}}, rd_h} : dmem_rd;
  assign merged = req_funct3[1:0] == 2'b00 ? (rd_buf_q & ~(32'h0000_00ff << bsh)) | ({24'b0, req_wdata[7:0]} << bsh)
                : req_funct3[1:0] == 2'b01 ? (rd_buf_q & ~(32'h0000_ffff << hsh)) | ({16'b0, req_wdata[15:0]} << hsh)
                : req_wdata;
  assign done = state_q == FIN;
  assign memaccess = state_q == RD || state_q == WR;
  assign dmem_we = state_q == WR;
  assign dmem_addr = memaccess ? {req_addr[31:2], 2'b00} : '0;
  assign dmem_wd = dmem_we ? merged : '0;
  assign load_data = load_data_q;
  assign access_err = access_err_q;
  assign bus_err = bus_err_q;
  assign stall = req_valid & ~done;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    rd_buf_d = rd_buf_q;
    load_data_d = '0;
    access_err_d = 1'b0;
    bus_err_d = 1'b0;
    case (state_q)
      IDLE: if (req_valid) begin
        cnt_d = '0;
        if (illegal || misaligned) begin
          state_d = FIN;
          access_err_d = 1'b1;
        end else state_d = (req_we && req_funct3 == 3'b010) ? WR : RD;
      end
      RD: if (timeout) begin
        state_d = FIN;
        bus_err_d = 1'b1;
      end else if (Dwait) cnt_d = cnt_q + 1'b1;
      else begin
        rd_buf_d = dmem_rd;
        cnt_d = '0;
        state_d = req_we ? WR : FIN;
        load_data_d = req_we ? '0 : ext;
      end
      WR: if (timeout) begin
        state_d = FIN;
        bus_err_d = 1'b1;
      end else if (Dwait) cnt_d = cnt_q + 1'b1;
      else state_d = FIN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rd_buf_q <= '0;
      load_data_q <= '0;
      access_err_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rd_buf_q <= rd_buf_d;
      load_data_q <= load_data_d;
      access_err_q <= access_err_d;
      bus_err_q <= bus_err_d;
    end
  end
endmodule

// File: doc/dmem_lsu_ctrl.md
Name: dmem_lsu_ctrl

Overview:
Requester-side load/store controller between the CPU MEM stage and the word-wide data-memory bus (Daddr/Dwritedata/Dwe/Dmemaccess/Dreaddata/Dwait). It turns RV32I LB/LH/LW/LBU/LHU/SB/SH/SW into bus accesses. It honours Dwait by holding the request stable until the wait is released. Because the bus has no byte enables, it performs read-modify-write for SB/SH, and it sign- or zero-extends load data.

Parameters:
WAIT_LIMIT, 15, max consecutive Dwait=1 cycles in one bus phase before bus_err is flagged.
CNT_W, 4, width of the wait counter; must satisfy 2^CNT_W > WAIT_LIMIT.

Ports:
clk  in  1  clock, all state on rising edge.
reset  in  1  synchronous, active-low reset (reset=0 resets on the next rising edge).
req_valid  in  1  CPU request present; CPU holds all req_* stable until done=1.
req_we  in  1  1=store, 0=load.
req_funct3  in  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
req_addr  in  32  byte address.
req_wdata  in  32  store data, right-aligned.
stall  out  1  req_valid & ~done; freezes the CPU pipeline.
done  out  1  one-cycle completion pulse.
load_data  out  32  extended load result, valid while done=1, otherwise 0.
access_err  out  1  valid with done: misaligned address or illegal funct3.
bus_err  out  1  valid with done: wait limit exceeded.
dmem_addr  out  32  {req_addr[31:2],2'b00} during bus phases, otherwise 0.
dmem_wd  out  32  word written to memory.
dmem_we  out  1  write strobe.
memaccess  out  1  bus-phase active (drives Dmemaccess).
dmem_rd  in  32  read word; combinational while memaccess=1.
Dwait  in  1  memory wait; may be combinational from dmem_addr.

Behaviour:
- Reset values: state=IDLE; done, access_err, bus_err, dmem_we, memaccess = 0; load_data, dmem_wd, dmem_addr = 0; wait counter = 0. A reset during any phase aborts it, no done is issued, and no further writes occur after that edge.
- States: IDLE, RD, WR, FIN.
- IDLE, req_valid=1:
  - Illegal funct3 (load 011/110/111, store >010), or misaligned (H with addr[0]=1, W with addr[1:0]!=0) -> FIN with access_err=1 and no bus activity.
  - Load, SB, or SH -> RD.
  - SW -> WR.
- RD: memaccess=1, dmem_we=0. On an edge with Dwait=0, capture dmem_rd into rd_buf.
  - Load -> FIN.
  - SB/SH -> WR.
- WR: memaccess=1, dmem_we=1.
  - SW: dmem_wd = req_wdata.
  - SB: dmem_wd = rd_buf with byte lane req_addr[1:0] replaced by req_wdata[7:0].
  - SH: dmem_wd = rd_buf with half lane req_addr[1] replaced by req_wdata[15:0].
  - Advance to FIN on an edge with Dwait=0. Repeated identical writes while Dwait=1 are permitted.
- Wait counter: cleared on entry to RD/WR, increments on each edge with Dwait=1. At the edge where it would exceed WAIT_LIMIT, go to FIN with bus_err=1 and abandon the RMW, with no write phase.
- FIN: done=1 for exactly one cycle, memaccess=0, then IDLE. load_data and the error flags are registered and held only in FIN.
- Load extraction uses lane req_addr[1:0]. B/H sign-extend bit 7/15; BU/HU zero-extend.
- Back-to-back: IDLE costs one cycle, so a new req_valid is first sampled in IDLE. No request is accepted in FIN.
- Latency with Dwait=0 (req_valid first seen in cycle 0):
  - LW/LB/LH: done in cycle 2.
  - SW: done in cycle 2.
  - SB/SH: done in cycle 3.
- Each Dwait=1 cycle adds one cycle per phase.

Test Plan:
- MEM[0x10]=0x8899AABB; LB addr 0x12, funct3 000 -> done in cycle 2, load_data=0xFFFFFF99. LBU same address -> 0x00000099.
- MEM[0x10]=0x8899AABB; SB addr 0x11, wdata 0x55 -> exactly one RD then one WR, final MEM[0x10]=0x889955BB, done in cycle 3.
- Word at 0x0C (memory asserts Dwait for 2 cycles); LH addr 0x0E, MEM[0x0C]=0x7FFF1234 -> dmem_addr held at 0x0C throughout, load_data=0x00007FFF, done in cycle 4.
- LW addr 0x06 -> access_err=1, memaccess never asserted, done in cycle 1. Store with funct3 100 -> access_err=1.
- Dwait tied to 1, SH addr 0x20 -> bus_err=1 after WAIT_LIMIT+1 wait edges, dmem_we never asserted, memory unchanged.
- SH addr 0x0E to a location held in wait; reset=0 asserted during RD -> next cycle state=IDLE with all outputs 0, no done pulse, memory unchanged.
